// File: rtl/dmem_bytelane.sv
// Byte-addressable big-endian data memory with byte/halfword/word access,
// alignment and range checking, 1-cycle response and an optional clear sweep.
module dmem_bytelane #(
    parameter int DEPTH          = 256,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          ready_q;
    logic          resp_valid_q;
    logic          err_q;
    logic          load_q;
    logic          sign_q;
    logic [1:0]    size_q;
    logic [1:0]    off_q;

    logic          accept;
    logic          bad;
    logic          clearing;
    logic          store_ok;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wrep;
    logic [31:0]   rword;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ext;

    assign accept   = req & ready_q & ~rst;
    assign clearing = (state_q == S_CLEAR) & ~rst;
    assign idx      = addr[AW+1:2];
    assign bad      = (size == 2'b11)
                    | ((size == 2'b01) & addr[0])
                    | ((size == 2'b10) & (addr[1:0] != 2'b00))
                    | ((addr >> (AW + 2)) != 32'd0);
    assign store_ok = accept & we & ~bad;

    // Lane 3 holds bits [31:24], i.e. the lowest byte address of the word.
    always_comb begin
        be   = 4'b1111;
        wrep = wdata;
        case (size)
            2'b00: begin
                be   = 4'b1000 >> addr[1:0];
                wrep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be   = addr[1] ? 4'b0011 : 4'b1100;
                wrep = {2{wdata[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = wdata;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0]    mem [DEPTH];
        logic [7:0]    rd_q;
        logic          wen;
        logic [AW-1:0] wa;
        logic [7:0]    wd;

        assign wen = clearing | (store_ok & be[gi]);
        assign wa  = clearing ? cnt_q : idx;
        assign wd  = clearing ? 8'h00 : wrep[gi*8 +: 8];

        always_ff @(posedge clk) begin
            if (wen) begin
                mem[wa] <= wd;
            end
            if (accept) begin
                rd_q <= mem[idx];
            end
        end
    end

    assign rword = {g_lane[3].rd_q, g_lane[2].rd_q, g_lane[1].rd_q, g_lane[0].rd_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            ready_q      <= !CLEAR_ON_RESET;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            load_q       <= 1'b0;
            sign_q       <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
        end else begin
            resp_valid_q <= accept;
            err_q        <= accept & bad;
            load_q       <= accept & ~we & ~bad;
            sign_q       <= sign;
            size_q       <= size;
            off_q        <= addr[1:0];
            case (state_q)
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Byte at offset k sits 8*(3-k) bits up from the LSB; ~off_q == 3-off_q.
    assign rd_byte = 8'(rword >> {~off_q, 3'b000});
    assign rd_half = off_q[1] ? rword[15:0] : rword[31:16];

    always_comb begin
        ext = rword;
        case (size_q)
            2'b00:   ext = sign_q ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
            2'b01:   ext = sign_q ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
            default: ext = rword;
        endcase
    end

    assign ready      = ready_q;
    assign resp_valid = resp_valid_q;
    assign err        = err_q;
    assign rdata      = (resp_valid_q & load_q) ? ext : 32'd0;

endmodule
